// File: rtl/kws_audio_pkg.sv
// Purpose: shared defaults and entry layout for the keyword-spotting audio ingress.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package kws_audio_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int CHANNELS_DEF = 2;
    localparam int DEPTH_DEF    = 16;

    // Channel tag width; a single-channel stream still carries a 1-bit tag.
    function automatic int chan_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    localparam int CHAN_W_DEF = chan_width(CHANNELS_DEF);

    // One FIFO entry. The top packs non-default widths in this same order,
    // chan in the upper bits and sample in the lower bits.
    typedef struct packed {
        logic [CHAN_W_DEF-1:0]   chan;
        logic [SAMPLE_W_DEF-1:0] sample;
    } kws_entry_t;

endpackage

// File: rtl/kws_sync_fifo.sv
// Purpose: single-clock first-word-fall-through FIFO with occupancy count.
// Latency: pushed word visible at pop_dat_o the cycle after the push.
// Backpressure: push while full is accepted only with a same-cycle pop; flush beats push/pop.
// Ports: push_i/push_dat_i write, pop_i read, flush_i clear, pop_dat_o head,
//        level_o occupancy, full_o/empty_o status.
module kws_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage is not reset; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

endmodule

// File: rtl/kws_audio_ingress.sv
// Purpose: captures pad audio samples on a synchronised strobe edge, tags channel, decimates frames, buffers in a FIFO.
// Latency: entry written on the edge cycle; out_valid rises after the 3rd clk edge following a pad_valid rise.
// Backpressure: out_valid/out_ready pop; a push into a full FIFO without a pop is dropped and sets sticky overflow.
// Ports: pad_sample/pad_valid pad input, enable/decim/flush/clr_ovf control,
//        out_data/out_chan/out_valid/out_ready stream out, level/overflow status.
module kws_audio_ingress
    import kws_audio_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [SAMPLE_W-1:0]                      pad_sample,
    input  logic                                     pad_valid,
    input  logic                                     enable,
    input  logic [3:0]                               decim,
    input  logic                                     flush,
    input  logic                                     clr_ovf,
    output logic [SAMPLE_W-1:0]                      out_data,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [$clog2(DEPTH):0]                   level,
    output logic                                     overflow
);

    localparam int CHAN_W  = chan_width(CHANNELS);
    localparam int ENTRY_W = CHAN_W + SAMPLE_W;

    logic              sync1_q, sync2_q, sync3_q;
    logic              pad_edge, accept, push_req, push, pop, drop, chan_wrap;
    logic [CHAN_W-1:0] chan_cnt_q, chan_cnt_d;
    logic [3:0]        dec_cnt_q, dec_cnt_d;
    logic              overflow_q, overflow_d;
    logic              fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] push_dat, pop_dat;

    // Two flops resolve metastability; the third gives the previous level for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= pad_valid;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign pad_edge = sync2_q & ~sync3_q;

    always_comb begin
        accept     = pad_edge & enable;
        push_req   = accept & (dec_cnt_q == 4'd0) & ~flush;
        pop        = out_valid & out_ready;
        push       = push_req & (~fifo_full | pop);
        drop       = push_req & fifo_full & ~pop;
        chan_wrap  = (chan_cnt_q == CHAN_W'(CHANNELS - 1));
        chan_cnt_d = chan_cnt_q;
        dec_cnt_d  = dec_cnt_q;
        if (!enable || flush) begin
            chan_cnt_d = '0;
            dec_cnt_d  = 4'd0;
        end else if (accept) begin
            // Dropped samples still advance the channel so tagging stays aligned.
            chan_cnt_d = chan_wrap ? '0 : chan_cnt_q + 1'b1;
            // decim is only looked at here, so a mid-frame change lands on the next frame boundary.
            // >= (not ==) recovers cleanly if decim was lowered below the running count.
            if (chan_wrap) begin
                dec_cnt_d = (dec_cnt_q >= decim) ? 4'd0 : dec_cnt_q + 4'd1;
            end
        end
        overflow_d = overflow_q;
        if (clr_ovf)   overflow_d = 1'b0;
        else if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_cnt_q <= '0;
            dec_cnt_q  <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            chan_cnt_q <= chan_cnt_d;
            dec_cnt_q  <= dec_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign push_dat = {chan_cnt_q, pad_sample};

    kws_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .flush_i    (flush),
        .pop_dat_o  (pop_dat),
        .level_o    (level),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = pop_dat[SAMPLE_W-1:0];
    assign out_chan  = pop_dat[ENTRY_W-1:SAMPLE_W];
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_kws_audio_ingress.sv
// Purpose: self-checking bench for kws_audio_ingress against a queue-based reference model.
// Latency: model predicts the FIFO write on the 3rd clk edge after each pad_valid rise.
// Backpressure: bench drives out_ready per cycle and predicts drops/overflow from model occupancy.
module tb_kws_audio_ingress;
    import kws_audio_pkg::*;

    localparam int SW = 16;
    localparam int CH = 2;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [SW-1:0] pad_sample = '0;
    logic          pad_valid = 1'b0;
    logic          enable = 1'b0;
    logic [3:0]    decim = 4'd0;
    logic          flush = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_data;
    logic [0:0]    out_chan;
    logic          out_valid;
    logic [2:0]    level;
    logic          overflow;

    kws_audio_ingress #(.SAMPLE_W(SW), .CHANNELS(CH), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pad_sample (pad_sample),
        .pad_valid  (pad_valid),
        .enable     (enable),
        .decim      (decim),
        .flush      (flush),
        .clr_ovf    (clr_ovf),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: expected FIFO contents, accepted-sample index since the
    // last counter clear, and the sticky overflow bit.
    kws_entry_t mq[$];
    int         k;
    bit         m_ovf;
    int         checks;
    int         failures;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One pad strobe; optional pop / flush / clr_ovf asserted in the capture cycle.
    task automatic send(input logic [SW-1:0] s, input bit pop_cap, input bit fl_cap, input bit clr_cap);
        kws_entry_t e;
        bit         keep;
        pad_sample = s;
        @(posedge clk);
        #2 pad_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_level", 32'(level), 32'(mq.size()));
        chk("pre_ovf", 32'(overflow), 32'(m_ovf));
        out_ready = pop_cap;
        flush     = fl_cap;
        clr_ovf   = clr_cap;
        if (pop_cap && !fl_cap && mq.size() > 0) begin
            chk("cap_pop_data", 32'(out_data), 32'(mq[0].sample));
            chk("cap_pop_chan", 32'(out_chan), 32'(mq[0].chan));
            void'(mq.pop_front());
        end
        if (fl_cap) begin
            mq.delete();
            k = 0;
        end else if (enable) begin
            // Sample k belongs to frame k/CH; only every (decim+1)-th frame is kept.
            e.chan   = 1'(k % CH);
            e.sample = s;
            keep     = ((k / CH) % (int'(decim) + 1)) == 0;
            k++;
            if (keep) begin
                if (mq.size() < DP) mq.push_back(e);
                else                m_ovf = 1'b1;
            end
        end
        if (clr_cap) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        flush     = 1'b0;
        clr_ovf   = 1'b0;
        pad_valid = 1'b0;
        chk("post_level", 32'(level), 32'(mq.size()));
        chk("post_ovf", 32'(overflow), 32'(m_ovf));
        chk("post_vld", 32'(out_valid), 32'(mq.size() != 0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        chk("pop_vld", 32'(out_valid), 32'd1);
        chk("pop_data", 32'(out_data), 32'(mq[0].sample));
        chk("pop_chan", 32'(out_chan), 32'(mq[0].chan));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        void'(mq.pop_front());
    endtask

    task automatic drain();
        while (mq.size() > 0) pop_one();
        chk("drain_vld", 32'(out_valid), 32'd0);
        chk("drain_level", 32'(level), 32'd0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        mq.delete();
        k = 0;
        chk("flush_level", 32'(level), 32'd0);
    endtask

    task automatic do_clr();
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        m_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        checks = 0;
        failures = 0;
        k = 0;
        m_ovf = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single sample into an empty FIFO: visible after the 3rd edge, chan 0.
        decim = 4'd0;
        send(16'h1234, 0, 0, 0);
        chk("t1_data", 32'(out_data), 32'h1234);
        chk("t1_chan", 32'(out_chan), 32'd0);
        drain();

        // decim=1: frames 0 and 2 kept -> A0,A1,A4,A5.
        do_flush();
        decim = 4'd1;
        for (int i = 0; i < 8; i++) send(16'hA000 + 16'(i), 0, 0, 0);
        chk("t2_level", 32'(level), 32'd4);
        drain();

        // Overfill a depth-4 FIFO, then clear the sticky flag.
        do_flush();
        decim = 4'd0;
        for (int i = 0; i < 5; i++) send(16'(32'hB000 + i), 0, 0, 0);
        chk("t3_level", 32'(level), 32'd4);
        chk("t3_ovf", 32'(overflow), 32'd1);
        do_clr();

        // Drop while full with clr_ovf in the same cycle: clear wins.
        send(16'hC1C1, 0, 0, 1);
        chk("t4_ovf", 32'(overflow), 32'd0);

        // Full FIFO with push and pop together: level holds, no overflow.
        send(16'h4040, 1, 0, 0);
        chk("t5_level", 32'(level), 32'd4);
        chk("t5_ovf", 32'(overflow), 32'd0);
        drain();

        // Flush coinciding with an edge: empties and restarts channel tagging.
        do_flush();
        for (int i = 0; i < 3; i++) send(16'(32'hD000 + i), 0, 0, 0);
        chk("t6_level3", 32'(level), 32'd3);
        send(16'hDEAD, 0, 1, 0);
        chk("t6_level0", 32'(level), 32'd0);
        chk("t6_vld", 32'(out_valid), 32'd0);
        send(16'h0041, 0, 0, 0);
        chk("t6_chan", 32'(out_chan), 32'd0);
        drain();

        // Reset mid-stream with level 2 and overflow set.
        do_flush();
        for (int i = 0; i < 5; i++) send(16'(32'hE000 + i), 0, 0, 0);
        pop_one();
        pop_one();
        chk("t7_level2", 32'(level), 32'd2);
        #3 rst_n = 1'b0;
        #1;
        chk("t7_rst_vld", 32'(out_valid), 32'd0);
        chk("t7_rst_level", 32'(level), 32'd0);
        chk("t7_rst_ovf", 32'(overflow), 32'd0);
        mq.delete();
        k = 0;
        m_ovf = 1'b0;
        @(posedge clk);
        #4 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(16'h0042, 0, 0, 0);
        chk("t7_data", 32'(out_data), 32'h0042);
        chk("t7_chan", 32'(out_chan), 32'd0);
        drain();

        // Randomised rounds: random decim, samples, capture-cycle pops and disabled strobes.
        for (int r = 0; r < 6; r++) begin
            int n;
            do_flush();
            decim = 4'($urandom_range(0, 3));
            n = $urandom_range(3, 10);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    enable = 1'b0;
                    k = 0;
                    send(16'($urandom), 0, 0, 0);
                    enable = 1'b1;
                end else begin
                    send(16'($urandom), $urandom_range(0, 3) == 0, 0, 0);
                end
            end
            drain();
            if (m_ovf) do_clr();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kws_audio_ingress.md
KWS_AUDIO_INGRESS -- requirements
Module: kws_audio_ingress

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, giving the audio sample width in bits.
REQ-002 SHALL have parameter CHANNELS, default 2, giving interleaved channels per frame (1..8).
REQ-003 SHALL have parameter DEPTH, default 16, giving FIFO entries (power of two, 4..256).
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port pad_sample, input, SAMPLE_W, sample bus from IO pads.
REQ-007 SHALL have port pad_valid, input, 1, asynchronous sample strobe from pad; a rising edge marks a new sample.
REQ-008 SHALL have port enable, input, 1, capture enable.
REQ-009 SHALL have port decim, input, 4, frame decimation ratio minus one.
REQ-010 SHALL have port flush, input, 1, synchronous FIFO and counter clear.
REQ-011 SHALL have port clr_ovf, input, 1, clears the overflow flag.
REQ-012 SHALL have port out_data, output, SAMPLE_W, head-of-FIFO sample.
REQ-013 SHALL have port out_chan, output, clog2(CHANNELS) with minimum 1, channel tag of out_data.
REQ-014 SHALL have port out_valid, output, 1, FIFO not empty.
REQ-015 SHALL have port out_ready, input, 1, consumer accepts the head entry.
REQ-016 SHALL have port level, output, clog2(DEPTH)+1, current FIFO occupancy.
REQ-017 SHALL have port overflow, output, 1, sticky flag set when a sample is dropped.

Function
REQ-018 SHALL synchronise pad_valid through two flops and register it a third time; edge = sync2 & ~sync3.
REQ-019 SHALL capture pad_sample on the edge cycle; the source holds pad_sample stable from 1 clk before the pad_valid rise to 3 clk after it.
REQ-020 SHALL ignore edges while enable=0.
REQ-021 SHALL tag each accepted edge with chan_cnt, then increment chan_cnt modulo CHANNELS.
REQ-022 SHALL keep frame counter dec_cnt, incremented when chan_cnt wraps and cleared to 0 when it would exceed decim.
REQ-023 SHALL push only samples whose frame has dec_cnt==0; decim=0 pushes every frame.
REQ-024 SHALL clear chan_cnt and dec_cnt synchronously while enable=0 or flush=1.
REQ-025 SHALL write each pushed entry on the edge cycle, so out_valid rises after the 3rd clk edge following a pad_valid rise into an empty FIFO.
REQ-026 SHALL pop on out_valid & out_ready, with out_data/out_chan presenting the head (first-word fall-through).
REQ-027 SHALL accept a push when full only if a pop occurs in the same cycle; level is unchanged in that case.
REQ-028 SHALL drop a push when full with no pop, set overflow, and still advance chan_cnt.
REQ-029 SHALL give clr_ovf priority over a same-cycle overflow set, leaving overflow 0.
REQ-030 SHALL empty the FIFO on flush (level=0 next cycle), taking priority over push and pop in that cycle.
REQ-031 SHALL change decim only at frame boundaries; values applied mid-frame take effect when chan_cnt next wraps.

Reset
REQ-032 SHALL, on rst_n low, asynchronously clear the sync flops, chan_cnt, dec_cnt, FIFO pointers, level, overflow, and out_valid.
REQ-033 SHALL treat out_data/out_chan as don't-care while out_valid=0; reset mid-transfer discards all entries.
REQ-034 SHALL treat rst_n deassertion as asynchronous in timing only, with the first edge detectable no earlier than 3 clk after release.

Structure
REQ-035 SHALL place default parameter values and the entry struct {chan, sample} in package kws_audio_pkg.
REQ-036 SHALL implement storage in one sub-module, kws_sync_fifo (parametrised width/depth, push/pop/flush, level, full/empty).

Verification
REQ-037 SHALL cover a single pulse with sample 0x1234 into an empty FIFO -> out_valid high after the 3rd edge, out_data=0x1234, out_chan=0.
REQ-038 SHALL cover CHANNELS=2, decim=1, 8 samples A0..A7 -> only A0,A1,A4,A5 output, with chans 0,1,0,1.
REQ-039 SHALL cover DEPTH=4, out_ready=0, 5 samples -> level=4, overflow=1, 5th dropped; then clr_ovf -> overflow=0.
REQ-040 SHALL cover a full FIFO with push and pop in the same cycle -> level stays 4, new sample becomes the tail, no overflow.
REQ-041 SHALL cover flush with level=3 and a simultaneous edge -> level=0, out_valid=0, next sample tagged chan 0.
REQ-042 SHALL cover rst_n low mid-stream with level=2 -> all outputs 0 immediately, overflow=0, capture resumes cleanly after release.
